// File: rtl/oled_pkg.sv
// ============================================================================
// Module : oled_pkg
// Brief  : Shared types and constants for the SSD1306 SPI streamer: FSM state
//          encoding, the 25-byte init command list and the resync commands.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package oled_pkg;

    typedef enum logic [3:0] {
        ST_RST_HOLD    = 4'd0,
        ST_PWR_WAIT    = 4'd1,
        ST_INIT_LOAD   = 4'd2,
        ST_INIT_SHIFT  = 4'd3,
        ST_INIT_NEXT   = 4'd4,
        ST_FETCH       = 4'd5,
        ST_DATA_SHIFT  = 4'd6,
        ST_DATA_NEXT   = 4'd7,
        ST_GAP         = 4'd8,
        ST_RSYNC_LOAD  = 4'd9,
        ST_RSYNC_SHIFT = 4'd10,
        ST_RSYNC_NEXT  = 4'd11
    } state_t;

    localparam int INIT_LEN    = 25;
    localparam int RESYNC_LEN  = 6;
    localparam int FRAME_BYTES = 1024;

    // Init list leaves the panel in horizontal addressing mode, display on.
    function automatic logic [7:0] init_rom(input logic [4:0] idx);
        logic [7:0] v;
        case (idx)
            5'd0:    v = 8'hAE;
            5'd1:    v = 8'hD5;
            5'd2:    v = 8'h80;
            5'd3:    v = 8'hA8;
            5'd4:    v = 8'h3F;
            5'd5:    v = 8'hD3;
            5'd6:    v = 8'h00;
            5'd7:    v = 8'h40;
            5'd8:    v = 8'h8D;
            5'd9:    v = 8'h14;
            5'd10:   v = 8'h20;
            5'd11:   v = 8'h00;
            5'd12:   v = 8'hA1;
            5'd13:   v = 8'hC8;
            5'd14:   v = 8'hDA;
            5'd15:   v = 8'h12;
            5'd16:   v = 8'h81;
            5'd17:   v = 8'hCF;
            5'd18:   v = 8'hD9;
            5'd19:   v = 8'hF1;
            5'd20:   v = 8'hDB;
            5'd21:   v = 8'h40;
            5'd22:   v = 8'hA4;
            5'd23:   v = 8'hA6;
            5'd24:   v = 8'hAF;
            default: v = 8'hE3;
        endcase
        return v;
    endfunction

    // Column range 0..127 then page range 0..7.
    function automatic logic [7:0] resync_cmd(input logic [2:0] idx);
        logic [7:0] v;
        case (idx)
            3'd0:    v = 8'h21;
            3'd1:    v = 8'h00;
            3'd2:    v = 8'h7F;
            3'd3:    v = 8'h22;
            3'd4:    v = 8'h00;
            3'd5:    v = 8'h07;
            default: v = 8'hE3;
        endcase
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_byte_tx.sv
// ============================================================================
// Module : spi_byte_tx
// Brief  : Mode-0 SPI byte shifter, MSB first; one byte takes 16*CLK_DIV clks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_byte_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    output logic       o_sclk,
    output logic       o_mosi,
    output logic       o_done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic             r_busy_q, w_busy_d;
    logic [DIV_W-1:0] r_div_q,  w_div_d;
    logic [3:0]       r_half_q, w_half_d;
    logic [7:0]       r_sh_q,   w_sh_d;
    logic             r_sclk_q, w_sclk_d;
    logic             r_done_q, w_done_d;

    always_comb begin
        w_busy_d = r_busy_q;
        w_div_d  = r_div_q;
        w_half_d = r_half_q;
        w_sh_d   = r_sh_q;
        w_sclk_d = r_sclk_q;
        w_done_d = 1'b0;
        if (!r_busy_q) begin
            if (i_start) begin
                w_busy_d = 1'b1;
                w_sh_d   = i_byte;
                w_div_d  = '0;
                w_half_d = 4'd0;
                w_sclk_d = 1'b0;
            end
        end else if (r_div_q == DIV_W'(CLK_DIV - 1)) begin
            w_div_d  = '0;
            w_half_d = r_half_q + 4'd1;
            if (!r_half_q[0]) begin
                w_sclk_d = 1'b1;
            end else begin
                // Falling edge: next bit goes out while sclk is low.
                w_sclk_d = 1'b0;
                w_sh_d   = {r_sh_q[6:0], 1'b0};
                if (r_half_q == 4'd15) begin
                    w_busy_d = 1'b0;
                    w_done_d = 1'b1;
                end
            end
        end else begin
            w_div_d = r_div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy_q <= 1'b0;
            r_div_q  <= '0;
            r_half_q <= 4'd0;
            r_sh_q   <= 8'h00;
            r_sclk_q <= 1'b0;
            r_done_q <= 1'b0;
        end else begin
            r_busy_q <= w_busy_d;
            r_div_q  <= w_div_d;
            r_half_q <= w_half_d;
            r_sh_q   <= w_sh_d;
            r_sclk_q <= w_sclk_d;
            r_done_q <= w_done_d;
        end
    end

    assign o_sclk = r_sclk_q;
    assign o_mosi = r_sh_q[7];
    assign o_done = r_done_q;

endmodule

`default_nettype wire

// File: rtl/oled_spi_streamer.sv
// ============================================================================
// Module : oled_spi_streamer
// Brief  : Resets and initialises a 128x64 SSD1306, then streams 1024-byte
//          frames fetched via byte_counter/data_to_send over 4-wire SPI.
//          Define OLED_FRAME_RESYNC_EN to prefix each frame with address cmds.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module oled_spi_streamer #(
    parameter int CLK_DIV          = 4,
    parameter int RESET_CYCLES     = 1000,
    parameter int POWERUP_CYCLES   = 100000,
    parameter int FRAME_GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] byte_counter,
    input  logic [7:0] data_to_send,
    output logic       oled_sclk,
    output logic       oled_mosi,
    output logic       oled_cs_n,
    output logic       oled_dc,
    output logic       oled_res_n,
    output logic       frame_done,
    output logic       busy_init
);

    import oled_pkg::*;

    localparam int CNT_MAX_A = (RESET_CYCLES > POWERUP_CYCLES) ? RESET_CYCLES : POWERUP_CYCLES;
    localparam int CNT_MAX_B = (CNT_MAX_A > FRAME_GAP_CYCLES) ? CNT_MAX_A : FRAME_GAP_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_B > 2) ? CNT_MAX_B : 2;
    localparam int CNT_W     = $clog2(CNT_MAX);

`ifdef OLED_FRAME_RESYNC_EN
    localparam state_t c_frame_start = ST_RSYNC_LOAD;
`else
    localparam state_t c_frame_start = ST_FETCH;
`endif

    state_t           r_state_q, w_state_d;
    logic [CNT_W-1:0] r_cnt_q,   w_cnt_d;
    logic [4:0]       r_idx_q,   w_idx_d;
    logic [9:0]       r_bc_q,    w_bc_d;
    logic             r_cs_n_q,  w_cs_n_d;
    logic             r_dc_q,    w_dc_d;
    logic             r_res_n_q, w_res_n_d;
    logic             r_fdone_q, w_fdone_d;
    logic             r_binit_q, w_binit_d;
    logic             w_tx_start;
    logic [7:0]       w_tx_byte;
    logic             w_tx_done;

    always_comb begin
        w_state_d  = r_state_q;
        w_cnt_d    = '0;
        w_idx_d    = r_idx_q;
        w_bc_d     = r_bc_q;
        w_cs_n_d   = r_cs_n_q;
        w_dc_d     = r_dc_q;
        w_res_n_d  = r_res_n_q;
        w_fdone_d  = 1'b0;
        w_binit_d  = r_binit_q;
        w_tx_start = 1'b0;
        w_tx_byte  = 8'h00;
        case (r_state_q)
            ST_RST_HOLD: begin
                if (r_cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
                    w_res_n_d = 1'b1;
                    w_state_d = ST_PWR_WAIT;
                end else begin
                    w_cnt_d = r_cnt_q + CNT_W'(1);
                end
            end
            ST_PWR_WAIT: begin
                if (r_cnt_q == CNT_W'(POWERUP_CYCLES - 1)) w_state_d = ST_INIT_LOAD;
                else w_cnt_d = r_cnt_q + CNT_W'(1);
            end
            ST_INIT_LOAD: begin
                w_cs_n_d   = 1'b0;
                w_dc_d     = 1'b0;
                w_tx_start = 1'b1;
                w_tx_byte  = init_rom(r_idx_q);
                w_state_d  = ST_INIT_SHIFT;
            end
            ST_INIT_SHIFT: if (w_tx_done) w_state_d = ST_INIT_NEXT;
            ST_INIT_NEXT: begin
                if (r_idx_q == 5'(INIT_LEN - 1)) begin
                    w_binit_d = 1'b0;
                    w_idx_d   = 5'd0;
                    w_state_d = c_frame_start;
                end else begin
                    w_idx_d   = r_idx_q + 5'd1;
                    w_state_d = ST_INIT_LOAD;
                end
            end
            // Index was updated on entry; the two-cycle wait covers the
            // controller's registered lookup before data_to_send is captured.
            ST_FETCH: begin
                w_cs_n_d = 1'b0;
                w_dc_d   = 1'b1;
                if (r_cnt_q == CNT_W'(1)) begin
                    w_tx_start = 1'b1;
                    w_tx_byte  = data_to_send;
                    w_state_d  = ST_DATA_SHIFT;
                end else begin
                    w_cnt_d = r_cnt_q + CNT_W'(1);
                end
            end
            ST_DATA_SHIFT: if (w_tx_done) w_state_d = ST_DATA_NEXT;
            ST_DATA_NEXT: begin
                if (r_bc_q == 10'(FRAME_BYTES - 1)) begin
                    w_fdone_d = 1'b1;
                    w_bc_d    = 10'd0;
                    if (FRAME_GAP_CYCLES > 0) begin
                        w_cs_n_d  = 1'b1;
                        w_state_d = ST_GAP;
                    end else begin
                        w_state_d = c_frame_start;
                    end
                end else begin
                    w_bc_d    = r_bc_q + 10'd1;
                    w_state_d = ST_FETCH;
                end
            end
            ST_GAP: begin
                if (r_cnt_q == CNT_W'(FRAME_GAP_CYCLES - 1)) begin
                    w_cs_n_d  = 1'b0;
                    w_state_d = c_frame_start;
                end else begin
                    w_cnt_d = r_cnt_q + CNT_W'(1);
                end
            end
`ifdef OLED_FRAME_RESYNC_EN
            ST_RSYNC_LOAD: begin
                w_cs_n_d   = 1'b0;
                w_dc_d     = 1'b0;
                w_tx_start = 1'b1;
                w_tx_byte  = resync_cmd(r_idx_q[2:0]);
                w_state_d  = ST_RSYNC_SHIFT;
            end
            ST_RSYNC_SHIFT: if (w_tx_done) w_state_d = ST_RSYNC_NEXT;
            ST_RSYNC_NEXT: begin
                if (r_idx_q == 5'(RESYNC_LEN - 1)) begin
                    w_idx_d   = 5'd0;
                    w_state_d = ST_FETCH;
                end else begin
                    w_idx_d   = r_idx_q + 5'd1;
                    w_state_d = ST_RSYNC_LOAD;
                end
            end
`endif
            default: w_state_d = ST_RST_HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= ST_RST_HOLD;
            r_cnt_q   <= '0;
            r_idx_q   <= 5'd0;
            r_bc_q    <= 10'd0;
            r_cs_n_q  <= 1'b1;
            r_dc_q    <= 1'b0;
            r_res_n_q <= 1'b0;
            r_fdone_q <= 1'b0;
            r_binit_q <= 1'b1;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_idx_q   <= w_idx_d;
            r_bc_q    <= w_bc_d;
            r_cs_n_q  <= w_cs_n_d;
            r_dc_q    <= w_dc_d;
            r_res_n_q <= w_res_n_d;
            r_fdone_q <= w_fdone_d;
            r_binit_q <= w_binit_d;
        end
    end

    spi_byte_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk     (clk),
        .rst     (reset),
        .i_start (w_tx_start),
        .i_byte  (w_tx_byte),
        .o_sclk  (oled_sclk),
        .o_mosi  (oled_mosi),
        .o_done  (w_tx_done)
    );

    assign byte_counter = r_bc_q;
    assign oled_cs_n    = r_cs_n_q;
    assign oled_dc      = r_dc_q;
    assign oled_res_n   = r_res_n_q;
    assign frame_done   = r_fdone_q;
    assign busy_init    = r_binit_q;

endmodule

`default_nettype wire

// File: tb/tb_oled_spi_streamer.sv
// ============================================================================
// Module : tb_oled_spi_streamer
// Brief  : Directed bench: reset timing, init capture, frame streaming/wrap,
//          mid-frame reset. Honours OLED_FRAME_RESYNC_EN when defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_oled_spi_streamer;

    localparam int CLK_DIV          = 2;
    localparam int RESET_CYCLES     = 10;
    localparam int POWERUP_CYCLES   = 20;
    localparam int FRAME_GAP_CYCLES = 5;
    // First to last sclk rise of a byte; plus the leading low and trailing
    // high half-periods this makes the 16*CLK_DIV byte time.
    localparam int SPAN             = 14 * CLK_DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] byte_counter;
    logic [7:0] data_to_send;
    logic       oled_sclk, oled_mosi, oled_cs_n, oled_dc, oled_res_n;
    logic       frame_done, busy_init;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] data;
        logic       dc;
        logic       dc_bad;
        logic       cs_bad;
        int         span;
    } rx_t;
    rx_t rx_q[$];

    logic [7:0] exp_init [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00,
                                  8'h40, 8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8,
                                  8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB,
                                  8'h40, 8'hA4, 8'hA6, 8'hAF};
`ifdef OLED_FRAME_RESYNC_EN
    logic [7:0] exp_resync [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
`endif

    oled_spi_streamer #(
        .CLK_DIV          (CLK_DIV),
        .RESET_CYCLES     (RESET_CYCLES),
        .POWERUP_CYCLES   (POWERUP_CYCLES),
        .FRAME_GAP_CYCLES (FRAME_GAP_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .byte_counter (byte_counter),
        .data_to_send (data_to_send),
        .oled_sclk    (oled_sclk),
        .oled_mosi    (oled_mosi),
        .oled_cs_n    (oled_cs_n),
        .oled_dc      (oled_dc),
        .oled_res_n   (oled_res_n),
        .frame_done   (frame_done),
        .busy_init    (busy_init)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Image controller: registered lookup, pixel byte = low 8 bits of index.
    always @(posedge clk) data_to_send <= byte_counter[7:0];

    int         mon_bits = 0;
    int         mon_first = 0;
    logic [7:0] mon_sh = 8'h00;
    logic       mon_prev = 1'b0;
    logic       mon_dc = 1'b0;
    logic       mon_dc_bad = 1'b0;
    logic       mon_cs_bad = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            mon_bits = 0;
            mon_prev = 1'b0;
            rx_q.delete();
        end else begin
            if (oled_sclk === 1'b1 && mon_prev === 1'b0) begin
                if (mon_bits == 0) begin
                    mon_first  = cyc;
                    mon_dc     = oled_dc;
                    mon_dc_bad = 1'b0;
                    mon_cs_bad = 1'b0;
                end
                if (oled_dc !== mon_dc) mon_dc_bad = 1'b1;
                if (oled_cs_n !== 1'b0) mon_cs_bad = 1'b1;
                mon_sh   = {mon_sh[6:0], oled_mosi};
                mon_bits = mon_bits + 1;
                if (mon_bits == 8) begin
                    rx_q.push_back('{data: mon_sh, dc: mon_dc, dc_bad: mon_dc_bad,
                                     cs_bad: mon_cs_bad, span: cyc - mon_first});
                    mon_bits = 0;
                end
            end
            mon_prev = oled_sclk;
        end
    end

    task automatic get_byte(output rx_t r, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        r  = '{data: 8'h00, dc: 1'b0, dc_bad: 1'b0, cs_bad: 1'b0, span: 0};
        while (!ok && n < 200) begin
            if (rx_q.size() > 0) begin
                r  = rx_q.pop_front();
                ok = 1'b1;
            end else begin
                @(posedge clk); #1;
                n++;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        int rise;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (byte_counter !== 10'd0) begin errors++; $display("FAIL reset_byte_counter got %0d want 0", byte_counter); end
        checks++; if (oled_sclk !== 1'b0)     begin errors++; $display("FAIL reset_sclk got %b want 0", oled_sclk); end
        checks++; if (oled_mosi !== 1'b0)     begin errors++; $display("FAIL reset_mosi got %b want 0", oled_mosi); end
        checks++; if (oled_cs_n !== 1'b1)     begin errors++; $display("FAIL reset_cs_n got %b want 1", oled_cs_n); end
        checks++; if (oled_dc !== 1'b0)       begin errors++; $display("FAIL reset_dc got %b want 0", oled_dc); end
        checks++; if (oled_res_n !== 1'b0)    begin errors++; $display("FAIL reset_res_n got %b want 0", oled_res_n); end
        checks++; if (frame_done !== 1'b0)    begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        checks++; if (busy_init !== 1'b1)     begin errors++; $display("FAIL reset_busy_init got %b want 1", busy_init); end
        reset = 1'b0;
        n = 1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (oled_res_n !== 1'b0) break;
            n++;
        end
        checks++; if (n != RESET_CYCLES) begin errors++; $display("FAIL res_n_low_cycles got %0d want %0d", n, RESET_CYCLES); end
        rise = cyc;
        for (int i = 0; i < 200 && oled_sclk !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (oled_sclk !== 1'b1 || (cyc - rise) < POWERUP_CYCLES) begin
            errors++; $display("FAIL powerup_wait sclk %b after %0d cycles want >= %0d", oled_sclk, cyc - rise, POWERUP_CYCLES);
        end
        checks++; if (busy_init !== 1'b1) begin errors++; $display("FAIL busy_init_first_byte got %b want 1", busy_init); end
    endtask

    task automatic test_init();
        rx_t r;
        bit  ok;
        for (int i = 0; i < 25; i++) begin
            get_byte(r, ok);
            checks++;
            if (!ok || r.data !== exp_init[i] || r.dc !== 1'b0 || r.dc_bad || r.cs_bad || r.span != SPAN) begin
                errors++;
                $display("FAIL init_byte[%0d] got ok=%0b data=%h dc=%b dc_bad=%b cs_bad=%b span=%0d want data=%h dc=0 span=%0d",
                         i, ok, r.data, r.dc, r.dc_bad, r.cs_bad, r.span, exp_init[i], SPAN);
            end
        end
        checks++; if (busy_init !== 1'b1) begin errors++; $display("FAIL busy_init_last_byte got %b want 1", busy_init); end
        for (int i = 0; i < 20 && busy_init === 1'b1; i++) begin
            @(posedge clk); #1;
        end
        checks++; if (busy_init !== 1'b0) begin errors++; $display("FAIL busy_init_clear got %b want 0", busy_init); end
    endtask

    task automatic test_frame_data(input int nbytes);
        rx_t        r;
        bit         ok;
        logic [7:0] exp_b;
`ifdef OLED_FRAME_RESYNC_EN
        for (int k = 0; k < 6; k++) begin
            get_byte(r, ok);
            checks++;
            if (!ok || r.data !== exp_resync[k] || r.dc !== 1'b0 || r.dc_bad || r.cs_bad) begin
                errors++;
                $display("FAIL resync_byte[%0d] got ok=%0b data=%h dc=%b want data=%h dc=0", k, ok, r.data, r.dc, exp_resync[k]);
            end
        end
`endif
        for (int i = 0; i < nbytes; i++) begin
            exp_b = i[7:0];
            get_byte(r, ok);
            checks++;
            if (!ok || r.data !== exp_b || r.dc !== 1'b1 || r.dc_bad || r.cs_bad || r.span != SPAN) begin
                errors++;
                $display("FAIL data_byte[%0d] got ok=%0b data=%h dc=%b dc_bad=%b cs_bad=%b span=%0d want data=%h dc=1 span=%0d",
                         i, ok, r.data, r.dc, r.dc_bad, r.cs_bad, r.span, exp_b, SPAN);
            end
        end
    endtask

    task automatic test_frame_wrap();
        int n;
        for (int i = 0; i < 200 && frame_done !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL frame_done_seen got %b want 1", frame_done); end
        checks++; if (byte_counter !== 10'd0) begin errors++; $display("FAIL wrap_byte_counter got %0d want 0", byte_counter); end
        n = (oled_cs_n === 1'b1) ? 1 : 0;
        @(posedge clk); #1;
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL frame_done_width got %b want 0 on second cycle", frame_done); end
        for (int i = 0; i < 50 && oled_cs_n === 1'b1; i++) begin
            n++;
            @(posedge clk); #1;
        end
        checks++; if (n != FRAME_GAP_CYCLES) begin errors++; $display("FAIL gap_cs_n_high got %0d want %0d", n, FRAME_GAP_CYCLES); end
    endtask

    task automatic test_reset_midframe();
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (oled_cs_n !== 1'b1)     begin errors++; $display("FAIL midreset_cs_n got %b want 1", oled_cs_n); end
        checks++; if (oled_res_n !== 1'b0)    begin errors++; $display("FAIL midreset_res_n got %b want 0", oled_res_n); end
        checks++; if (byte_counter !== 10'd0) begin errors++; $display("FAIL midreset_byte_counter got %0d want 0", byte_counter); end
        checks++; if (oled_sclk !== 1'b0)     begin errors++; $display("FAIL midreset_sclk got %b want 0", oled_sclk); end
        checks++; if (busy_init !== 1'b1)     begin errors++; $display("FAIL midreset_busy_init got %b want 1", busy_init); end
        reset = 1'b0;
        test_init();
        test_frame_data(4);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init();
        test_frame_data(1024);
        test_frame_wrap();
        test_frame_data(501);
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
